instruction_decode_hazard: RTL and testbench
============================================

# instruction_decode_hazard

Parametrised ID pipeline stage for the MIPS-subset core: decodes the IF/ID instruction, reads an internal write-first register file, resolves branches and jumps (BEQ, BNE, J, JAL, JR, JALR) in ID with forwarding from EX/MEM, and detects load-use and branch-operand hazards. It drives the registered ID/EX pipeline register, a stall request to IF, and a redirect/flush to IF.

## Interface
Parameters:
- NB_DATA, 32: datapath/PC width, ≥ 32; immediates are sign-extended to NB_DATA.
- NB_ADDR, 5: register address width; the register file holds 2**NB_ADDR entries.

Ports:
- i_clk  in  1  clock; everything on posedge.
- i_reset  in  1  synchronous, active-high.
- i_valid  in  1  IF/ID holds a real instruction.
- i_pc4  in  NB_DATA  PC+4 of the ID instruction.
- i_instruction  in  32  instruction word.
- i_wb_write, i_wb_addr[NB_ADDR], i_wb_data[NB_DATA]  in  WB write port.
- i_ex_wb_write, i_ex_mem_read  in  1 each  flags of the instruction currently in EX.
- i_ex_dst  in  NB_ADDR  destination of the EX instruction.
- i_mem_wb_write, i_mem_mem_read  in  1 each  flags of the instruction in MEM.
- i_mem_dst  in  NB_ADDR  destination of the MEM instruction.
- i_mem_result  in  NB_DATA  ALU result in MEM.
- o_stall  out  1  hold PC and IF/ID (combinational).
- o_jump  out  1  redirect PC and flush IF/ID (combinational).
- o_jump_addr  out  NB_DATA  redirect target (combinational).
- o_valid  out  1  ID/EX holds a real instruction.
- o_RA, o_RB, o_inmediato, o_pc4  out  NB_DATA  ID/EX data.
- o_rs, o_rt, o_rd  out  NB_ADDR; o_opcode, o_funct  out  6; o_shamt  out  5.
- o_wb_write, o_wb_mem_to_reg, o_mem_read, o_mem_write, o_alu_src, o_reg_dst, o_link  out  1 each.
- o_alu_op  out  2.

## Operation
- Fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0]. rs, rt and rd are zero-extended/truncated to NB_ADDR.
- Register file:
  - Register 0 always reads 0; writes to register 0 are ignored.
  - Write-first: when i_wb_write is set and i_wb_addr equals a read address (≠0), the read returns i_wb_data in the same cycle.
- Control decode:
  - R-type (op 0): wb_write=1, mem_to_reg=1, reg_dst=1, alu_src=0, alu_op=10.
  - Load (op[5]=1, op[3]=0): wb_write=1, mem_to_reg=0, mem_read=1, alu_src=1, alu_op=00.
  - Store (op[5]=1, op[3]=1): mem_write=1, alu_src=1, alu_op=00.
  - Immediate (op[5:3]=001): wb_write=1, mem_to_reg=1, alu_src=1, reg_dst=0, alu_op=11.
  - JR (op 0, funct 001000): wb_write=0, alu_op=01.
  - JALR (funct 001001): link=1, wb_write=1, reg_dst=1.
  - JAL (op 000011): link=1, wb_write=1, o_rd=31.
  - BEQ (000100), BNE (000101), J (000010): no writes, alu_op=01.
  - Any other opcode: all write/read flags 0, alu_op=01.
- Operand use:
  - rs is used by everything except J and JAL.
  - rt is used by R-type, stores, BEQ and BNE.
- Hazards: m = register address nonzero and equal to a used operand.
  - Load-use: i_ex_mem_read and m(i_ex_dst) -> stall.
  - Branch/JR/JALR operand from EX: i_ex_wb_write and m(i_ex_dst) -> stall.
  - Branch/JR/JALR operand from a load in MEM: i_mem_mem_read and m(i_mem_dst) -> stall.
  - Otherwise, if i_mem_wb_write and m(i_mem_dst), the compare/JR operand takes i_mem_result.
- Targets:
  - BEQ/BNE: i_pc4 + (sext(imm) << 2).
  - J/JAL: {i_pc4[NB_DATA-1:28], addr26, 2'b00}.
  - JR/JALR: forwarded RA.
- o_jump = i_valid & ~o_stall & (taken branch | J | JAL | JR | JALR). o_jump_addr is don't-care when o_jump=0.
- Stall and invalid slots:
  - On stall, ID/EX loads a bubble: o_valid=0 and all control flags 0; data fields are don't-care.
  - When i_valid=0: no stall, no jump, and ID/EX loads a bubble.

## Timing
- On i_reset, at the next posedge:
  - All ID/EX outputs go to 0.
  - All registers are cleared.
  - Reset overrides a WB write in the same cycle.
- o_stall, o_jump and o_jump_addr are combinational from the current inputs. ID/EX outputs appear one cycle after the instruction is in ID.
- A load-use hazard costs 1 stall cycle.
- A branch whose operand is produced in EX by an ALU instruction costs 1 stall cycle.
- A branch whose operand is produced by a load in EX costs 2 stall cycles.
- When o_stall and a WB write coincide, the write still commits.

## Test plan
- Reset, then read r0 and r5 -> o_RA=0, o_RB=0, o_valid=0, all flags 0.
- WB writes r3=0x1234 while ID decodes ADD r1,r3,r3 -> next cycle o_RA=o_RB=0x1234 (write-first bypass).
- LW r2 in EX (i_ex_mem_read=1, i_ex_dst=2), ID decodes ADD r4,r2,r0 -> o_stall=1, next o_valid=0. Drop the EX load -> o_stall=0, o_valid=1 next cycle.
- BEQ r1,r2,+3 with r1=r2=7, i_pc4=0x100 -> o_jump=1, o_jump_addr=0x10C. BNE with the same operands -> o_jump=0.
- BEQ r1,r0 with MEM producing r1 (i_mem_result=0, non-load) -> forwarded, o_jump=1. Same with i_mem_mem_read=1 -> o_stall=1, o_jump=0.
- JAL 0x40 at i_pc4=0x200 -> o_jump_addr=0x100, next o_rd=31, o_link=1, o_wb_write=1, o_pc4=0x200.

Source files
------------

// File: rtl/instruction_decode_hazard.sv
// ID stage of the MIPS-subset pipeline: decode, write-first register file,
// branch/jump resolution with EX/MEM forwarding, hazard stall and ID/EX register.
module instruction_decode_hazard #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_pc4,
  input  logic [31:0]        i_instruction,
  input  logic               i_wb_write,
  input  logic [NB_ADDR-1:0] i_wb_addr,
  input  logic [NB_DATA-1:0] i_wb_data,
  input  logic               i_ex_wb_write,
  input  logic               i_ex_mem_read,
  input  logic [NB_ADDR-1:0] i_ex_dst,
  input  logic               i_mem_wb_write,
  input  logic               i_mem_mem_read,
  input  logic [NB_ADDR-1:0] i_mem_dst,
  input  logic [NB_DATA-1:0] i_mem_result,
  output logic               o_stall,
  output logic               o_jump,
  output logic [NB_DATA-1:0] o_jump_addr,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_RA,
  output logic [NB_DATA-1:0] o_RB,
  output logic [NB_DATA-1:0] o_inmediato,
  output logic [NB_DATA-1:0] o_pc4,
  output logic [NB_ADDR-1:0] o_rs,
  output logic [NB_ADDR-1:0] o_rt,
  output logic [NB_ADDR-1:0] o_rd,
  output logic [5:0]         o_opcode,
  output logic [5:0]         o_funct,
  output logic [4:0]         o_shamt,
  output logic               o_wb_write,
  output logic               o_wb_mem_to_reg,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_alu_src,
  output logic               o_reg_dst,
  output logic               o_link,
  output logic [1:0]         o_alu_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam int         NREGS    = 2 ** NB_ADDR;

  typedef struct packed {
    logic       wb_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic       link;
    logic [1:0] alu_op;
  } ctl_t;

  typedef struct packed {
    logic               valid;
    ctl_t               ctl;
    logic [NB_DATA-1:0] ra;
    logic [NB_DATA-1:0] rb;
    logic [NB_DATA-1:0] imm;
    logic [NB_DATA-1:0] pc4;
    logic [NB_ADDR-1:0] rs;
    logic [NB_ADDR-1:0] rt;
    logic [NB_ADDR-1:0] rd;
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [4:0]         shamt;
  } idex_t;

  function automatic logic [NB_DATA-1:0] rf_read(
    input logic [NB_ADDR-1:0] addr,
    input logic [NB_DATA-1:0] stored,
    input logic               we,
    input logic [NB_ADDR-1:0] waddr,
    input logic [NB_DATA-1:0] wdata
  );
    if (addr == '0) begin
      return '0;
    end else if (we && (waddr == addr)) begin
      return wdata;
    end else begin
      return stored;
    end
  endfunction

  function automatic logic operand_match(
    input logic [NB_ADDR-1:0] dst,
    input logic [NB_ADDR-1:0] rs,
    input logic [NB_ADDR-1:0] rt,
    input logic               use_rs,
    input logic               use_rt
  );
    return (dst != '0) && ((use_rs && (dst == rs)) || (use_rt && (dst == rt)));
  endfunction

  logic [NB_DATA-1:0] regs_q [NREGS];
  logic [NB_DATA-1:0] regs_d [NREGS];
  idex_t              idex_q, idex_d;

  logic [5:0]         op_s, funct_s;
  logic [NB_ADDR-1:0] rs_s, rt_s, rd_s;
  logic [NB_DATA-1:0] imm_ext_s, rf_a_s, rf_b_s, cmp_a_s, cmp_b_s;
  logic [NB_DATA-1:0] br_target_s, j_target_s;
  logic is_r_s, is_jr_s, is_jalr_s, is_j_s, is_jal_s, is_beq_s, is_bne_s;
  logic use_rs_s, use_rt_s, br_class_s, m_ex_s, m_mem_s, taken_s, load_s;
  ctl_t ctl_s;

  assign op_s      = i_instruction[31:26];
  assign funct_s   = i_instruction[5:0];
  assign rs_s      = NB_ADDR'(i_instruction[25:21]);
  assign rt_s      = NB_ADDR'(i_instruction[20:16]);
  assign rd_s      = NB_ADDR'(i_instruction[15:11]);
  assign imm_ext_s = {{(NB_DATA-16){i_instruction[15]}}, i_instruction[15:0]};

  assign is_r_s    = (op_s == OP_RTYPE);
  assign is_jr_s   = is_r_s && (funct_s == FN_JR);
  assign is_jalr_s = is_r_s && (funct_s == FN_JALR);
  assign is_j_s    = (op_s == OP_J);
  assign is_jal_s  = (op_s == OP_JAL);
  assign is_beq_s  = (op_s == OP_BEQ);
  assign is_bne_s  = (op_s == OP_BNE);

  assign use_rs_s   = !(is_j_s || is_jal_s);
  assign use_rt_s   = is_r_s || (op_s[5] && op_s[3]) || is_beq_s || is_bne_s;
  assign br_class_s = is_beq_s || is_bne_s || is_jr_s || is_jalr_s;

  // Register file next state; entry 0 is never written
  always_comb begin
    for (int k = 0; k < NREGS; k++) begin
      regs_d[k] = (i_wb_write && (i_wb_addr == NB_ADDR'(k)) && (k != 0)) ? i_wb_data : regs_q[k];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  assign rf_a_s = rf_read(rs_s, regs_q[rs_s], i_wb_write, i_wb_addr, i_wb_data);
  assign rf_b_s = rf_read(rt_s, regs_q[rt_s], i_wb_write, i_wb_addr, i_wb_data);

  // Hazards; stalls on EX producers take priority over MEM forwarding
  assign m_ex_s  = operand_match(i_ex_dst, rs_s, rt_s, use_rs_s, use_rt_s);
  assign m_mem_s = operand_match(i_mem_dst, rs_s, rt_s, use_rs_s, use_rt_s);
  assign o_stall = i_valid && ((i_ex_mem_read && m_ex_s) ||
                               (br_class_s && i_ex_wb_write && m_ex_s) ||
                               (br_class_s && i_mem_mem_read && m_mem_s));

  assign cmp_a_s = (i_mem_wb_write && (i_mem_dst != '0) && (i_mem_dst == rs_s)) ? i_mem_result : rf_a_s;
  assign cmp_b_s = (i_mem_wb_write && (i_mem_dst != '0) && (i_mem_dst == rt_s)) ? i_mem_result : rf_b_s;
  assign taken_s = (is_beq_s && (cmp_a_s == cmp_b_s)) || (is_bne_s && (cmp_a_s != cmp_b_s));

  assign br_target_s = i_pc4 + {imm_ext_s[NB_DATA-3:0], 2'b00};
  assign j_target_s  = {i_pc4[NB_DATA-1:28], i_instruction[25:0], 2'b00};

  assign o_jump = i_valid && !o_stall && (taken_s || is_j_s || is_jal_s || is_jr_s || is_jalr_s);

  always_comb begin
    if (is_jr_s || is_jalr_s) begin
      o_jump_addr = cmp_a_s;
    end else if (is_j_s || is_jal_s) begin
      o_jump_addr = j_target_s;
    end else begin
      o_jump_addr = br_target_s;
    end
  end

  // Control decode
  always_comb begin
    ctl_s        = '0;
    ctl_s.alu_op = 2'b01;
    casez (op_s)
      OP_RTYPE: begin
        ctl_s.wb_write   = 1'b1;
        ctl_s.mem_to_reg = 1'b1;
        ctl_s.reg_dst    = 1'b1;
        ctl_s.alu_op     = 2'b10;
        case (funct_s)
          FN_JR: begin
            ctl_s.wb_write = 1'b0;
            ctl_s.alu_op   = 2'b01;
          end
          FN_JALR: ctl_s.link = 1'b1;
          default: ctl_s.link = 1'b0;
        endcase
      end
      OP_JAL: begin
        ctl_s.wb_write   = 1'b1;
        ctl_s.mem_to_reg = 1'b1;
        ctl_s.link       = 1'b1;
      end
      6'b001???: begin
        ctl_s.wb_write   = 1'b1;
        ctl_s.mem_to_reg = 1'b1;
        ctl_s.alu_src    = 1'b1;
        ctl_s.alu_op     = 2'b11;
      end
      6'b1?0???: begin
        ctl_s.wb_write = 1'b1;
        ctl_s.mem_read = 1'b1;
        ctl_s.alu_src  = 1'b1;
        ctl_s.alu_op   = 2'b00;
      end
      6'b1?1???: begin
        ctl_s.mem_write = 1'b1;
        ctl_s.alu_src   = 1'b1;
        ctl_s.alu_op    = 2'b00;
      end
      default: ctl_s.alu_op = 2'b01;
    endcase
  end

  // Stalled or empty slots enter ID/EX as a bubble
  assign load_s = i_valid && !o_stall;

  always_comb begin
    idex_d        = '0;
    idex_d.valid  = load_s;
    idex_d.ctl    = load_s ? ctl_s : '0;
    idex_d.ra     = rf_a_s;
    idex_d.rb     = rf_b_s;
    idex_d.imm    = imm_ext_s;
    idex_d.pc4    = i_pc4;
    idex_d.rs     = rs_s;
    idex_d.rt     = rt_s;
    idex_d.rd     = is_jal_s ? NB_ADDR'(5'd31) : rd_s;
    idex_d.opcode = op_s;
    idex_d.funct  = funct_s;
    idex_d.shamt  = i_instruction[10:6];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign o_valid         = idex_q.valid;
  assign o_RA            = idex_q.ra;
  assign o_RB            = idex_q.rb;
  assign o_inmediato     = idex_q.imm;
  assign o_pc4           = idex_q.pc4;
  assign o_rs            = idex_q.rs;
  assign o_rt            = idex_q.rt;
  assign o_rd            = idex_q.rd;
  assign o_opcode        = idex_q.opcode;
  assign o_funct         = idex_q.funct;
  assign o_shamt         = idex_q.shamt;
  assign o_wb_write      = idex_q.ctl.wb_write;
  assign o_wb_mem_to_reg = idex_q.ctl.mem_to_reg;
  assign o_mem_read      = idex_q.ctl.mem_read;
  assign o_mem_write     = idex_q.ctl.mem_write;
  assign o_alu_src       = idex_q.ctl.alu_src;
  assign o_reg_dst       = idex_q.ctl.reg_dst;
  assign o_link          = idex_q.ctl.link;
  assign o_alu_op        = idex_q.ctl.alu_op;

endmodule

// File: tb/tb_instruction_decode_hazard.sv
// Scoreboard bench for instruction_decode_hazard: directed vectors push expected
// combinational and ID/EX responses; a negedge monitor pops and compares them.
module tb_instruction_decode_hazard;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] pc4, instr;
  logic        wb_we;
  logic [4:0]  wb_a;
  logic [31:0] wb_d;
  logic        ex_wb, ex_mr;
  logic [4:0]  ex_dst;
  logic        mem_wb, mem_mr;
  logic [4:0]  mem_dst;
  logic [31:0] mem_res;

  logic        stall, jump, o_valid;
  logic [31:0] jaddr, ra, rb, imm, o_pc4;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  opcode, funct;
  logic        o_wb, o_m2r, o_mr, o_mw, o_as, o_rdst, o_link;
  logic [1:0]  o_aluop;

  instruction_decode_hazard #(.NB_DATA(32), .NB_ADDR(5)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_pc4(pc4), .i_instruction(instr),
    .i_wb_write(wb_we), .i_wb_addr(wb_a), .i_wb_data(wb_d),
    .i_ex_wb_write(ex_wb), .i_ex_mem_read(ex_mr), .i_ex_dst(ex_dst),
    .i_mem_wb_write(mem_wb), .i_mem_mem_read(mem_mr), .i_mem_dst(mem_dst),
    .i_mem_result(mem_res),
    .o_stall(stall), .o_jump(jump), .o_jump_addr(jaddr), .o_valid(o_valid),
    .o_RA(ra), .o_RB(rb), .o_inmediato(imm), .o_pc4(o_pc4),
    .o_rs(rs), .o_rt(rt), .o_rd(rd), .o_opcode(opcode), .o_funct(funct), .o_shamt(shamt),
    .o_wb_write(o_wb), .o_wb_mem_to_reg(o_m2r), .o_mem_read(o_mr), .o_mem_write(o_mw),
    .o_alu_src(o_as), .o_reg_dst(o_rdst), .o_link(o_link), .o_alu_op(o_aluop)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    int          cyc;
    logic        st;
    logic        jp;
    logic        ca;
    logic [31:0] ja;
  } comb_exp_t;

  typedef struct {
    string       nm;
    int          cyc;
    logic        vld;
    logic [8:0]  ctl;
    logic [8:0]  mask;
    logic        cd;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        crp;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } reg_exp_t;

  comb_exp_t comb_q[$];
  reg_exp_t  reg_q[$];
  int cyc_cnt = 0;
  int n_vec = 0;
  int n_miscmp = 0;

  // ctl bit order: wb_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst, link, alu_op[1:0]
  localparam logic [8:0] CTL_R     = 9'b110001010;
  localparam logic [8:0] CTL_LOAD  = 9'b101010000;
  localparam logic [8:0] MSK_LOAD  = 9'b111110111;
  localparam logic [8:0] CTL_STORE = 9'b000110000;
  localparam logic [8:0] MSK_STORE = 9'b101110111;
  localparam logic [8:0] CTL_IMM   = 9'b110010011;
  localparam logic [8:0] CTL_BR    = 9'b000000001;
  localparam logic [8:0] MSK_BR    = 9'b101100111;
  localparam logic [8:0] CTL_JAL   = 9'b100000100;
  localparam logic [8:0] CTL_JR    = 9'b000000001;
  localparam logic [8:0] MSK_JR    = 9'b100000011;
  localparam logic [8:0] CTL_JALR  = 9'b100001100;
  localparam logic [8:0] MSK_ALL   = 9'b111111111;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [31:0] r_ins(input int s, input int t, input int d, input logic [5:0] fn);
    return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int s, input int t, input logic [15:0] im);
    return {op, 5'(s), 5'(t), im};
  endfunction

  function automatic comb_exp_t ce(input string n, input logic st, input logic jp, input logic ca, input logic [31:0] ja);
    comb_exp_t e;
    e.nm = n; e.cyc = 0; e.st = st; e.jp = jp; e.ca = ca; e.ja = ja;
    return e;
  endfunction

  function automatic reg_exp_t re(input string n, input logic v, input logic [8:0] c, input logic [8:0] m,
                                  input logic cd, input logic [31:0] a, input logic [31:0] b,
                                  input logic crp, input logic [4:0] d, input logic [31:0] p);
    reg_exp_t e;
    e.nm = n; e.cyc = 0; e.vld = v; e.ctl = c; e.mask = m;
    e.cd = cd; e.ra = a; e.rb = b; e.crp = crp; e.rd = d; e.pc4 = p;
    return e;
  endfunction

  function automatic reg_exp_t bubble(input string n);
    return re(n, 1'b0, 9'h000, MSK_ALL, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; valid = 1'b0; pc4 = 32'h0; instr = 32'h0;
    wb_we = 1'b0; wb_a = 5'd0; wb_d = 32'h0;
    ex_wb = 1'b0; ex_mr = 1'b0; ex_dst = 5'd0;
    mem_wb = 1'b0; mem_mr = 1'b0; mem_dst = 5'd0; mem_res = 32'h0;
  endtask

  task automatic issue(input comb_exp_t c, input reg_exp_t r);
    c.cyc = cyc_cnt;
    r.cyc = cyc_cnt;
    comb_q.push_back(c);
    reg_q.push_back(r);
    n_vec++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: comb outputs belong to this cycle's vector, ID/EX to the previous one
  initial begin
    forever begin
      @(negedge clk);
      while (comb_q.size() > 0 && comb_q[0].cyc <= cyc_cnt) begin
        comb_exp_t c;
        c = comb_q.pop_front();
        chk({c.nm, ".stall"}, {31'd0, stall}, {31'd0, c.st});
        chk({c.nm, ".jump"}, {31'd0, jump}, {31'd0, c.jp});
        if (c.ca) chk({c.nm, ".jump_addr"}, jaddr, c.ja);
      end
      while (reg_q.size() > 0 && reg_q[0].cyc < cyc_cnt) begin
        reg_exp_t r;
        r = reg_q.pop_front();
        chk({r.nm, ".o_valid"}, {31'd0, o_valid}, {31'd0, r.vld});
        chk({r.nm, ".ctl"},
            {23'd0, ({o_wb, o_m2r, o_mr, o_mw, o_as, o_rdst, o_link, o_aluop} & r.mask)},
            {23'd0, r.ctl});
        if (r.cd) begin
          chk({r.nm, ".o_RA"}, ra, r.ra);
          chk({r.nm, ".o_RB"}, rb, r.rb);
        end
        if (r.crp) begin
          chk({r.nm, ".o_rd"}, {27'd0, rd}, {27'd0, r.rd});
          chk({r.nm, ".o_pc4"}, o_pc4, r.pc4);
        end
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset wins over a valid instruction and a WB write to r5
    idle(); rst = 1'b1; valid = 1'b1; pc4 = 32'h8; instr = r_ins(0, 5, 1, 6'h20);
    wb_we = 1'b1; wb_a = 5'd5; wb_d = 32'hDEAD;
    issue(ce("reset", 1'b0, 1'b0, 1'b0, 32'h0), re("reset", 1'b0, 9'h000, MSK_ALL, 1'b1, 32'h0, 32'h0, 1'b1, 5'd0, 32'h0));

    idle(); valid = 1'b1; pc4 = 32'h10; instr = r_ins(0, 5, 1, 6'h20);
    issue(ce("r0_r5", 1'b0, 1'b0, 1'b0, 32'h0), re("r0_r5", 1'b1, CTL_R, MSK_ALL, 1'b1, 32'h0, 32'h0, 1'b1, 5'd1, 32'h10));

    idle(); valid = 1'b1; pc4 = 32'h14; instr = r_ins(3, 3, 1, 6'h20);
    wb_we = 1'b1; wb_a = 5'd3; wb_d = 32'h1234;
    issue(ce("wb_bypass", 1'b0, 1'b0, 1'b0, 32'h0), re("wb_bypass", 1'b1, CTL_R, MSK_ALL, 1'b1, 32'h1234, 32'h1234, 1'b1, 5'd1, 32'h14));

    idle(); valid = 1'b1; pc4 = 32'h18; instr = r_ins(3, 0, 6, 6'h20);
    issue(ce("wb_commit", 1'b0, 1'b0, 1'b0, 32'h0), re("wb_commit", 1'b1, CTL_R, MSK_ALL, 1'b1, 32'h1234, 32'h0, 1'b1, 5'd6, 32'h18));

    idle(); instr = i_ins(6'b000100, 1, 1, 16'h0003); ex_mr = 1'b1; ex_dst = 5'd1;
    wb_we = 1'b1; wb_a = 5'd1; wb_d = 32'h7;
    issue(ce("invalid", 1'b0, 1'b0, 1'b0, 32'h0), bubble("invalid"));

    // Load-use stall; the coincident WB write to r2 must still commit
    idle(); valid = 1'b1; pc4 = 32'h20; instr = r_ins(2, 0, 4, 6'h20);
    ex_mr = 1'b1; ex_wb = 1'b1; ex_dst = 5'd2; wb_we = 1'b1; wb_a = 5'd2; wb_d = 32'h7;
    issue(ce("load_use", 1'b1, 1'b0, 1'b0, 32'h0), bubble("load_use"));

    idle(); valid = 1'b1; pc4 = 32'h20; instr = r_ins(2, 0, 4, 6'h20);
    issue(ce("load_use_clr", 1'b0, 1'b0, 1'b0, 32'h0), re("load_use_clr", 1'b1, CTL_R, MSK_ALL, 1'b1, 32'h7, 32'h0, 1'b1, 5'd4, 32'h20));

    idle(); valid = 1'b1; pc4 = 32'h100; instr = i_ins(6'b000100, 1, 2, 16'h0003);
    issue(ce("beq_taken", 1'b0, 1'b1, 1'b1, 32'h10C), re("beq_taken", 1'b1, CTL_BR, MSK_BR, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0));

    idle(); valid = 1'b1; pc4 = 32'h100; instr = i_ins(6'b000101, 1, 2, 16'h0003);
    issue(ce("bne_not", 1'b0, 1'b0, 1'b0, 32'h0), re("bne_not", 1'b1, CTL_BR, MSK_BR, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0));

    idle(); valid = 1'b1; pc4 = 32'h100; instr = i_ins(6'b000100, 1, 0, 16'hFFFF);
    mem_wb = 1'b1; mem_dst = 5'd1; mem_res = 32'h0;
    issue(ce("beq_fwd", 1'b0, 1'b1, 1'b1, 32'hFC), re("beq_fwd", 1'b1, CTL_BR, MSK_BR, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0));

    idle(); valid = 1'b1; pc4 = 32'h100; instr = i_ins(6'b000100, 1, 0, 16'hFFFF);
    mem_wb = 1'b1; mem_mr = 1'b1; mem_dst = 5'd1; mem_res = 32'h0;
    issue(ce("beq_memload", 1'b1, 1'b0, 1'b0, 32'h0), bubble("beq_memload"));

    idle(); valid = 1'b1; pc4 = 32'h200; instr = {6'b000011, 26'h40};
    issue(ce("jal", 1'b0, 1'b1, 1'b1, 32'h100), re("jal", 1'b1, CTL_JAL, CTL_JAL, 1'b0, 32'h0, 32'h0, 1'b1, 5'd31, 32'h200));

    idle(); valid = 1'b1; pc4 = 32'h100; instr = i_ins(6'b000100, 1, 2, 16'h0003);
    ex_wb = 1'b1; ex_dst = 5'd1;
    issue(ce("beq_ex_alu", 1'b1, 1'b0, 1'b0, 32'h0), bubble("beq_ex_alu"));

    idle(); valid = 1'b1; pc4 = 32'h104; instr = r_ins(1, 0, 0, 6'b001000);
    issue(ce("jr", 1'b0, 1'b1, 1'b1, 32'h7), re("jr", 1'b1, CTL_JR, MSK_JR, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0));

    idle(); valid = 1'b1; pc4 = 32'h104; instr = r_ins(1, 0, 0, 6'b001000);
    mem_wb = 1'b1; mem_dst = 5'd1; mem_res = 32'h400;
    issue(ce("jr_fwd", 1'b0, 1'b1, 1'b1, 32'h400), re("jr_fwd", 1'b1, CTL_JR, MSK_JR, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0));

    // J does not read rs, so a load in EX hitting its rs bit-field is harmless
    idle(); valid = 1'b1; pc4 = 32'h3000_0010; instr = {6'b000010, 26'h0200001};
    ex_mr = 1'b1; ex_dst = 5'd1;
    issue(ce("j_nouse", 1'b0, 1'b1, 1'b1, 32'h3080_0004), re("j_nouse", 1'b1, CTL_BR, MSK_BR, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0));

    idle(); valid = 1'b1; pc4 = 32'h300; instr = i_ins(6'b100011, 1, 7, 16'h0004);
    issue(ce("lw", 1'b0, 1'b0, 1'b0, 32'h0), re("lw", 1'b1, CTL_LOAD, MSK_LOAD, 1'b1, 32'h7, 32'h0, 1'b0, 5'd0, 32'h0));

    idle(); valid = 1'b1; pc4 = 32'h304; instr = i_ins(6'b101011, 1, 2, 16'h0008);
    issue(ce("sw", 1'b0, 1'b0, 1'b0, 32'h0), re("sw", 1'b1, CTL_STORE, MSK_STORE, 1'b1, 32'h7, 32'h7, 1'b0, 5'd0, 32'h0));

    idle(); valid = 1'b1; pc4 = 32'h304; instr = i_ins(6'b101011, 1, 2, 16'h0008);
    ex_mr = 1'b1; ex_dst = 5'd2;
    issue(ce("sw_load_use", 1'b1, 1'b0, 1'b0, 32'h0), bubble("sw_load_use"));

    idle(); valid = 1'b1; pc4 = 32'h308; instr = i_ins(6'b001000, 1, 9, 16'h0010);
    ex_mr = 1'b1; ex_dst = 5'd9;
    issue(ce("addi_rt", 1'b0, 1'b0, 1'b0, 32'h0), re("addi_rt", 1'b1, CTL_IMM, MSK_ALL, 1'b1, 32'h7, 32'h0, 1'b0, 5'd0, 32'h0));

    idle(); valid = 1'b1; pc4 = 32'h30C; instr = r_ins(0, 0, 1, 6'h20);
    ex_mr = 1'b1; ex_dst = 5'd0;
    issue(ce("r0_nohaz", 1'b0, 1'b0, 1'b0, 32'h0), re("r0_nohaz", 1'b1, CTL_R, MSK_ALL, 1'b1, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0));

    idle(); valid = 1'b1; pc4 = 32'h40; instr = r_ins(1, 0, 31, 6'b001001);
    issue(ce("jalr", 1'b0, 1'b1, 1'b1, 32'h7), re("jalr", 1'b1, CTL_JALR, CTL_JALR, 1'b0, 32'h0, 32'h0, 1'b1, 5'd31, 32'h40));

    idle();
    issue(ce("idle", 1'b0, 1'b0, 1'b0, 32'h0), bubble("idle"));

    repeat (3) @(posedge clk);
    #1;
    chk("drain", comb_q.size() + reg_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
